// File: rtl/k_and_s_pkg.sv
// Shared K&S types: instruction decode enum, opcode bytes, ALU operation codes.
// Also holds the opcode decode helpers used by datapath.
package k_and_s_pkg;

  typedef enum logic [3:0] {
    I_NOP, I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR,
    I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_HALT
  } decoded_instruction_type;

  localparam logic [7:0] OPC_NOP    = 8'h00;
  localparam logic [7:0] OPC_BRANCH = 8'h01;
  localparam logic [7:0] OPC_BZERO  = 8'h02;
  localparam logic [7:0] OPC_BNEG   = 8'h03;
  localparam logic [7:0] OPC_BNNEG  = 8'h0A;
  localparam logic [7:0] OPC_BNZERO = 8'h0B;
  localparam logic [7:0] OPC_LOAD   = 8'h81;
  localparam logic [7:0] OPC_STORE  = 8'h82;
  localparam logic [7:0] OPC_MOVE   = 8'h91;
  localparam logic [7:0] OPC_ADD    = 8'hA1;
  localparam logic [7:0] OPC_SUB    = 8'hA2;
  localparam logic [7:0] OPC_AND    = 8'hA3;
  localparam logic [7:0] OPC_OR     = 8'hA4;
  localparam logic [7:0] OPC_HALT   = 8'hFF;

  localparam logic [1:0] OP_OR  = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;

  function automatic decoded_instruction_type decode_opcode(input logic [7:0] opc);
    case (opc)
      OPC_BRANCH: decode_opcode = I_BRANCH;
      OPC_BZERO:  decode_opcode = I_BZERO;
      OPC_BNEG:   decode_opcode = I_BNEG;
      OPC_BNNEG:  decode_opcode = I_BNNEG;
      OPC_BNZERO: decode_opcode = I_BNZERO;
      OPC_LOAD:   decode_opcode = I_LOAD;
      OPC_STORE:  decode_opcode = I_STORE;
      OPC_MOVE:   decode_opcode = I_MOVE;
      OPC_ADD:    decode_opcode = I_ADD;
      OPC_SUB:    decode_opcode = I_SUB;
      OPC_AND:    decode_opcode = I_AND;
      OPC_OR:     decode_opcode = I_OR;
      OPC_HALT:   decode_opcode = I_HALT;
      default:    decode_opcode = I_NOP;
    endcase
  endfunction

  // NOP is a listed opcode, so it cannot be distinguished by the enum alone.
  function automatic logic opcode_known(input logic [7:0] opc);
    opcode_known = (opc == OPC_NOP) || (decode_opcode(opc) != I_NOP);
  endfunction

endpackage

// File: rtl/ks_alu.sv
// K&S ALU: combinational OR/ADD/SUB/AND on 16-bit operands with raw flags.
// Zero latency; no flow control.
module ks_alu
  import k_and_s_pkg::*;
(
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic [1:0]  op_i,
  output logic [15:0] result_o,
  output logic        zero_o,
  output logic        neg_o,
  output logic        uovf_o,
  output logic        sovf_o
);

  logic [16:0] res17;

  always_comb begin
    res17  = 17'd0;
    uovf_o = 1'b0;
    sovf_o = 1'b0;
    case (op_i)
      OP_ADD: begin
        res17  = {1'b0, a_i} + {1'b0, b_i};
        uovf_o = res17[16];
        sovf_o = (a_i[15] == b_i[15]) && (res17[15] != a_i[15]);
      end
      OP_SUB: begin
        // Bit 16 of the widened difference is the borrow (A < B unsigned).
        res17  = {1'b0, a_i} - {1'b0, b_i};
        uovf_o = res17[16];
        sovf_o = (a_i[15] != b_i[15]) && (res17[15] != a_i[15]);
      end
      OP_AND:  res17 = {1'b0, a_i & b_i};
      default: res17 = {1'b0, a_i | b_i};
    endcase
  end

  assign result_o = res17[15:0];
  assign zero_o   = (res17[15:0] == 16'd0);
  assign neg_o    = res17[15];

endmodule

// File: rtl/datapath.sv
// K&S datapath: PC, IR, decode, 4x16 register file, ALU and flags; executes control_unit strobes.
// Optional KS_ILLEGAL_OP_EN adds a sticky illegal_op output for unlisted opcodes.
module datapath
  import k_and_s_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    branch,
  input  logic                    pc_enable,
  input  logic                    ir_enable,
  input  logic                    write_reg_enable,
  input  logic                    addr_sel,
  input  logic                    c_sel,
  input  logic [1:0]              operation,
  input  logic                    flags_reg_enable,
  output decoded_instruction_type decoded_instruction,
  output logic                    zero_op,
  output logic                    neg_op,
  output logic                    unsigned_overflow,
  output logic                    signed_overflow,
`ifdef KS_ILLEGAL_OP_EN
  output logic                    illegal_op,
`endif
  output logic [ADDR_W-1:0]       ram_addr,
  input  logic [DATA_W-1:0]       data_in,
  output logic [DATA_W-1:0]       data_out
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [3:0]        flags_q, flags_d;

  logic [1:0]        a_idx, b_idx, wr_idx;
  logic [DATA_W-1:0] a_dat, b_dat, wr_dat, alu_res;
  logic              alu_zero, alu_neg, alu_uovf, alu_sovf;

  assign decoded_instruction = decode_opcode(ir_q[15:8]);

  assign a_idx  = ir_q[3:2];
  assign b_idx  = (decoded_instruction == I_MOVE) ? a_idx : ir_q[1:0];
  assign wr_idx = (decoded_instruction == I_LOAD) ? ir_q[6:5] : ir_q[5:4];
  assign a_dat  = regs_q[a_idx];
  assign b_dat  = regs_q[b_idx];
  assign wr_dat = c_sel ? alu_res : data_in;

  assign data_out = regs_q[ir_q[6:5]];
  assign ram_addr = addr_sel ? pc_q : ir_q[4:0];

  ks_alu u_alu (
    .a_i      (a_dat),
    .b_i      (b_dat),
    .op_i     (operation),
    .result_o (alu_res),
    .zero_o   (alu_zero),
    .neg_o    (alu_neg),
    .uovf_o   (alu_uovf),
    .sovf_o   (alu_sovf)
  );

  always_comb begin
    pc_d    = pc_q;
    ir_d    = ir_q;
    flags_d = flags_q;
    if (pc_enable) pc_d = branch ? ir_q[4:0] : pc_q + 1'b1;
    if (ir_enable) ir_d = data_in;
    if (flags_reg_enable) flags_d = {alu_zero, alu_neg, alu_uovf, alu_sovf};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= '0;
      ir_q    <= '0;
      flags_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
      if (write_reg_enable) regs_q[wr_idx] <= wr_dat;
    end
  end

  assign {zero_op, neg_op, unsigned_overflow, signed_overflow} = flags_q;

`ifdef KS_ILLEGAL_OP_EN
  logic illegal_q, illegal_d;

  assign illegal_d = illegal_q | ~opcode_known(ir_q[15:8]);

  always_ff @(posedge clk) begin
    if (!rst_n) illegal_q <= 1'b0;
    else        illegal_q <= illegal_d;
  end

  assign illegal_op = illegal_q;
`endif

endmodule
